// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory port and the decode-side port of
// the fetch stage.
//
// Handshakes:
//   imem_req/imem_gnt   - a request transfers when imem_req and imem_gnt are
//                         both high at a rising edge. imem_gnt is ignored
//                         while imem_req is low.
//   imem_rvalid         - one in-order response per granted request. It
//                         arrives at least one cycle after its grant. There
//                         is no backpressure on this path.
//   inst_valid/inst_ready - an instruction transfers when both are high at a
//                         rising edge. inst/pc/pc4 stay stable while
//                         inst_valid is high and inst_ready is low, unless a
//                         redirect discards the instruction.
//   redirect            - single-cycle control-flow change. It overrides
//                         every other action in that cycle.
//
// Modports:
//   master - the fetch stage
//   slave  - memory, execute and decode as seen from outside
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, pc, pc4,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, pc, pc4,
    output inst_ready
  );
endinterface

// File: rtl/fetch.sv
// fetch: RV32I instruction fetch stage.
//
// This stage owns the program counter and issues word requests to
// instruction memory. Returned words are buffered with their PCs in a small
// FIFO. The FIFO head is presented to decode as inst/pc/pc4. A redirect from
// execute re-targets the PC, flushes the FIFO and marks every outstanding
// response as stale.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high reset
//   bus - fetch_if.master. It carries the imem request/grant/response
//         signals, the redirect inputs and the decode valid/ready port.
//
// Parameters:
//   RESET_PC   - address of the first fetch after reset
//   FIFO_DEPTH - instruction buffer depth. It is also the credit limit on
//                in-flight plus buffered instructions. Must be a power of
//                two and at least 2.
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] kill;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] tag_wr, tag_rd;
  logic [PW-1:0] fifo_wr, fifo_rd;
  logic [31:0]   tag_mem   [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];

  logic          grant, resp, push, pop;
  logic [CW:0]   used;
  logic          unused_rpc_lo;

  // Redirect targets are always word aligned, so the low bits are not used.
  assign unused_rpc_lo = ^bus.redirect_pc[1:0];

  always_comb begin
    used           = {1'b0, inflight} + {1'b0, fifo_count};
    // Requests depend on state, rst and redirect only, never on imem_gnt.
    bus.imem_req   = !rst && !bus.redirect && (used < CREDITS);
    bus.imem_addr  = fetch_pc;
    grant          = bus.imem_req && bus.imem_gnt;
    resp           = bus.imem_rvalid;
    // A response is buffered only if it belongs to the current path.
    push           = resp && !bus.redirect && (kill == '0);
    bus.inst_valid = (fifo_count != '0) && !bus.redirect;
    pop            = bus.inst_valid && bus.inst_ready;
    bus.inst       = bus.inst_valid ? fifo_inst[fifo_rd] : NOP;
    bus.pc         = bus.inst_valid ? fifo_pc[fifo_rd] : 32'h0;
    bus.pc4        = bus.pc + 32'd4;
  end

  // Storage arrays carry no reset. Their contents are qualified by the
  // pointers and counters below.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
      fifo_inst[fifo_wr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      inflight   <= '0;
      kill       <= '0;
      fifo_count <= '0;
      tag_wr     <= '0;
      tag_rd     <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
    end else if (bus.redirect) begin
      fetch_pc   <= {bus.redirect_pc[31:2], 2'b00};
      fifo_count <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      // A response arriving now is dropped, but it still retires its tag.
      // Every request still outstanding after this cycle becomes stale,
      // including any that were already marked stale.
      inflight   <= inflight - CW'(resp);
      kill       <= inflight - CW'(resp);
      if (resp) begin
        tag_rd <= tag_rd + PW'(1);
      end
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_wr   <= tag_wr + PW'(1);
      end
      if (resp) begin
        tag_rd <= tag_rd + PW'(1);
        if (kill != '0) begin
          kill <= kill - CW'(1);
        end
      end
      inflight <= inflight + CW'(grant) - CW'(resp);
      if (push) begin
        fifo_wr <= fifo_wr + PW'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end
endmodule
